fifo_burst_packer: RTL and testbench

FIFO_BURST_PACKER -- requirements
Module: fifo_burst_packer

---
 rtl/fifo_burst_packer.sv | 148 ++++++++++++++
 tb/tb_fifo_burst_packer.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_burst_packer.sv
// Packs 16-bit words popped from an upstream prefetch FIFO into 64-bit beats,
// grouped into bursts of BURST_LEN beats, with flush to close partial beats/bursts.
module fifo_burst_packer #(
  parameter int          BURST_LEN = 16,
  parameter logic [15:0] PAD_WORD  = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        rd_en,
  input  logic        rd_vld,
  input  logic [15:0] rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last,
  input  logic        flush,
  output logic        flush_done,
  output logic        busy
);

  // Handshake: a beat transfers on the cycle where out_valid && out_ready;
  // out_data/out_keep/out_last hold steady while out_valid waits for out_ready.
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] HOLD = 1'b1;

  logic [0:0]  state;
  logic [1:0]  word_cnt;
  logic [7:0]  beat_cnt;
  logic        flush_pend;
  logic        hold_flush;
  logic [63:0] data_r;
  logic [3:0]  keep_r;
  logic        last_r;
  logic        done_r;

  logic        eff_pend;
  logic        beat_end;
  logic [2:0]  fill_n;
  logic [63:0] data_n;
  logic [63:0] pad_data;
  logic [3:0]  part_keep;

  assign rd_en     = rd_vld && (state == FILL) && !flush_pend;
  assign eff_pend  = flush_pend || flush;
  assign beat_end  = (beat_cnt == 8'(BURST_LEN - 1));
  assign out_valid = (state == HOLD);
  assign out_data  = data_r;
  assign out_keep  = keep_r;
  assign out_last  = last_r;
  assign flush_done = done_r;
  assign busy      = (word_cnt != 2'd0) || (beat_cnt != 8'd0) || flush_pend || out_valid;

  // Lane image after this cycle's word (if any) has been merged in.
  always_comb begin
    data_n = data_r;
    if (rd_en) begin
      case (word_cnt)
        2'd0:    data_n[15:0]  = rd_data;
        2'd1:    data_n[31:16] = rd_data;
        2'd2:    data_n[47:32] = rd_data;
        default: data_n[63:48] = rd_data;
      endcase
    end
    fill_n   = {1'b0, word_cnt} + {2'b00, rd_en};
    pad_data = data_n;
    for (int i = 0; i < 4; i++) begin
      if (3'(i) >= fill_n) pad_data[16*i +: 16] = PAD_WORD;
    end
    case (fill_n)
      3'd1:    part_keep = 4'b0001;
      3'd2:    part_keep = 4'b0011;
      3'd3:    part_keep = 4'b0111;
      default: part_keep = 4'b0000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= FILL;
      word_cnt   <= 2'd0;
      beat_cnt   <= 8'd0;
      flush_pend <= 1'b0;
      hold_flush <= 1'b0;
      data_r     <= 64'd0;
      keep_r     <= 4'd0;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        FILL: begin
          data_r <= data_n;
          if (fill_n == 3'd4) begin
            // A flush landing on the 4th word closes the burst with this full beat.
            state      <= HOLD;
            word_cnt   <= 2'd0;
            keep_r     <= 4'b1111;
            last_r     <= beat_end || eff_pend;
            hold_flush <= eff_pend;
            flush_pend <= eff_pend;
          end else if (eff_pend) begin
            word_cnt <= 2'd0;
            if (fill_n != 3'd0) begin
              state      <= HOLD;
              data_r     <= pad_data;
              keep_r     <= part_keep;
              last_r     <= 1'b1;
              hold_flush <= 1'b1;
              flush_pend <= 1'b1;
            end else if (beat_cnt != 8'd0) begin
              state      <= HOLD;
              data_r     <= {4{PAD_WORD}};
              keep_r     <= 4'b0000;
              last_r     <= 1'b1;
              hold_flush <= 1'b1;
              flush_pend <= 1'b1;
            end else begin
              flush_pend <= 1'b0;
              done_r     <= 1'b1;
            end
          end else begin
            word_cnt <= fill_n[1:0];
          end
        end
        HOLD: begin
          if (out_ready) begin
            state    <= FILL;
            beat_cnt <= last_r ? 8'd0 : beat_cnt + 8'd1;
            keep_r   <= 4'd0;
            last_r   <= 1'b0;
            if (hold_flush) begin
              hold_flush <= 1'b0;
              flush_pend <= 1'b0;
              done_r     <= 1'b1;
            end else begin
              flush_pend <= eff_pend;
            end
          end else begin
            flush_pend <= eff_pend;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_packer.sv
// Bench for fifo_burst_packer: word-queue model of beats/bursts/flushes checked
// every cycle, plus directed scenarios with literal expectations.
module tb_fifo_burst_packer;

  localparam int          BURST_LEN = 16;
  localparam logic [15:0] PAD       = 16'h0000;

  logic        clk;
  logic        rst;
  logic        rd_en;
  logic        rd_vld;
  logic [15:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [3:0]  out_keep;
  logic        out_last;
  logic        flush;
  logic        flush_done;
  logic        busy;

  fifo_burst_packer #(.BURST_LEN(BURST_LEN), .PAD_WORD(PAD)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_vld(rd_vld), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_keep(out_keep), .out_last(out_last), .flush(flush),
    .flush_done(flush_done), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // ---------------- model ----------------
  // exp_q entry: {closed_by_flush, last, keep[3:0], data[63:0]}
  logic [15:0] pend_w[$];
  logic [69:0] exp_q[$];
  logic [68:0] hs_log[$];
  int          hs_cyc[$];
  int          done_cyc[$];
  int          model_beats = 0;
  bit          done_due = 0;
  bit          just_full = 0;

  function automatic void model_word(logic [15:0] w);
    logic [63:0] d;
    bit          l;
    pend_w.push_back(w);
    if (pend_w.size() == 4) begin
      d = {pend_w[3], pend_w[2], pend_w[1], pend_w[0]};
      l = (model_beats == BURST_LEN - 1);
      model_beats = l ? 0 : model_beats + 1;
      exp_q.push_back({1'b0, l, 4'hf, d});
      pend_w.delete();
      just_full = 1;
    end
  endfunction

  function automatic void model_flush();
    logic [69:0] e;
    logic [63:0] d;
    logic [3:0]  k;
    if (just_full) begin
      e = exp_q[exp_q.size()-1];
      e[69] = 1'b1;
      e[68] = 1'b1;
      exp_q[exp_q.size()-1] = e;
      model_beats = 0;
    end else if (pend_w.size() > 0) begin
      d = {4{PAD}};
      k = 4'b0000;
      for (int i = 0; i < pend_w.size(); i++) begin
        d[16*i +: 16] = pend_w[i];
        k[i] = 1'b1;
      end
      exp_q.push_back({1'b1, 1'b1, k, d});
      pend_w.delete();
      model_beats = 0;
    end else if (model_beats > 0) begin
      exp_q.push_back({1'b1, 1'b1, 4'b0000, {4{PAD}}});
      model_beats = 0;
    end else begin
      done_due = 1;
    end
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    bit          exp_done;
    logic [69:0] e;
    if (rst) begin
      pend_w.delete();
      exp_q.delete();
      model_beats = 0;
      done_due = 0;
      just_full = 0;
    end else begin
      exp_done = done_due;
      done_due = 0;
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("rd_en", rd_en, rd_vld && exp_q.size() == 0);
      chk("flush_done", flush_done, exp_done);
      chk("busy", busy, pend_w.size() != 0 || model_beats != 0 || exp_q.size() != 0);
      if (flush_done) done_cyc.push_back(cycle);
      if (out_valid && exp_q.size() > 0) begin
        e = exp_q[0];
        chk("out_data", out_data, e[63:0]);
        chk("out_keep", out_keep, e[67:64]);
        chk("out_last", out_last, e[68]);
        if (out_ready) begin
          hs_log.push_back({out_last, out_keep, out_data});
          hs_cyc.push_back(cycle);
          exp_q.pop_front();
          if (e[69]) done_due = 1;
        end
      end
      just_full = 0;
      if (rd_en && rd_vld) model_word(rd_data);
      if (flush) model_flush();
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] w, input bit fl);
    int n = 0;
    bit got = 0;
    rd_vld  = 1'b1;
    rd_data = w;
    flush   = fl;
    do begin
      @(negedge clk);
      got = rd_en;
      cyc();
      flush = 1'b0;
      n++;
    end while (!got && n < 50);
    chk("feed_timeout", got, 1'b1);
  endtask

  task automatic idle();
    rd_vld  = 1'b0;
    rd_data = 16'($urandom_range(0, 16'hffff));
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 100);
    chk("drain_timeout", n < 100, 1'b1);
    cyc();
  endtask

  task automatic run_burst(input logic [15:0] base, input logic [63:0] beat0);
    hs_log.delete();
    hs_cyc.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 64; i++) feed(base + 16'(i + 1), 1'b0);
    idle();
    drain();
    chk("burst_beats", hs_log.size(), 16);
    if (hs_log.size() == 16) begin
      chk("burst_beat0", hs_log[0][63:0], beat0);
      for (int b = 0; b < 16; b++) chk("burst_last", hs_log[b][68], b == 15);
      for (int b = 1; b < 16; b++) chk("beat_spacing", hs_cyc[b] - hs_cyc[b-1], 5);
    end
  endtask

  // ---------------- scenarios ----------------
  initial begin
    rst = 1'b1; rd_vld = 1'b0; rd_data = 16'h0; out_ready = 1'b1; flush = 1'b0;
    repeat (3) cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_out_keep", out_keep, 4'd0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    cyc();

    // full burst, streaming input
    run_burst(16'h0000, 64'h0004_0003_0002_0001);

    // back-pressure: beat held for 10 cycles
    hs_log.delete();
    out_ready = 1'b0;
    feed(16'h0011, 1'b0); feed(16'h0022, 1'b0); feed(16'h0033, 1'b0); feed(16'h0044, 1'b0);
    rd_data = 16'h5555;
    repeat (10) begin
      @(negedge clk);
      chk("hold_rd_en", rd_en, 1'b0);
      chk("hold_valid", out_valid, 1'b1);
      chk("hold_data", out_data, 64'h0044_0033_0022_0011);
      cyc();
    end
    idle();
    out_ready = 1'b1;
    drain();
    chk("hold_hs_count", hs_log.size(), 1);

    // partial beat flush
    hs_log.delete(); hs_cyc.delete(); done_cyc.delete();
    feed(16'hAAAA, 1'b0); feed(16'hBBBB, 1'b0);
    idle();
    pulse_flush();
    drain();
    repeat (2) cyc();
    chk("part_count", hs_log.size(), 1);
    if (hs_log.size() == 1) chk("part_beat", hs_log[0], {1'b1, 4'b0011, 64'h0000_0000_BBBB_AAAA});
    chk("part_done_seen", done_cyc.size(), 1);
    if (done_cyc.size() == 1 && hs_cyc.size() == 1) chk("part_done_time", done_cyc[0] - hs_cyc[0], 1);

    // two full beats then flush: empty closing beat
    hs_log.delete();
    for (int i = 0; i < 8; i++) feed(16'h0021 + 16'(i), 1'b0);
    idle();
    drain();
    pulse_flush();
    drain();
    chk("empty_count", hs_log.size(), 3);
    if (hs_log.size() == 3) begin
      chk("empty_b0_last", hs_log[0][68], 1'b0);
      chk("empty_beat", hs_log[2], {1'b1, 4'b0000, 64'h0});
    end
    run_burst(16'h0100, 64'h0104_0103_0102_0101);

    // idle flush
    hs_log.delete();
    pulse_flush();
    @(negedge clk);
    chk("idle_done", flush_done, 1'b1);
    chk("idle_busy", busy, 1'b0);
    cyc();
    repeat (3) begin
      @(negedge clk);
      chk("idle_busy_after", busy, 1'b0);
      chk("idle_done_after", flush_done, 1'b0);
      cyc();
    end
    chk("idle_no_beat", hs_log.size(), 0);

    // flush coinciding with the 4th word
    hs_log.delete();
    feed(16'h0031, 1'b0); feed(16'h0032, 1'b0); feed(16'h0033, 1'b0); feed(16'h0034, 1'b1);
    idle();
    drain();
    repeat (4) cyc();
    chk("coinc_count", hs_log.size(), 1);
    if (hs_log.size() == 1) chk("coinc_beat", hs_log[0], {1'b1, 4'b1111, 64'h0034_0033_0032_0031});

    // reset mid-beat discards partial words
    hs_log.delete();
    feed(16'h0041, 1'b0); feed(16'h0042, 1'b0); feed(16'h0043, 1'b0);
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    cyc();
    feed(16'h0051, 1'b0); feed(16'h0052, 1'b0); feed(16'h0053, 1'b0); feed(16'h0054, 1'b0);
    idle();
    drain();
    chk("rst_count", hs_log.size(), 1);
    if (hs_log.size() == 1) chk("rst_beat", hs_log[0], {1'b0, 4'b1111, 64'h0054_0053_0052_0051});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
